// File: rtl/rgb_pkg.sv
// Shared types and default colour encodings for the runtime-writable palette.
package rgb_pkg;

  // 3-bit default colour codes: bit2 = red, bit1 = green, bit0 = blue
  localparam logic [2:0] BLACK   = 3'd0;
  localparam logic [2:0] BLUE    = 3'd1;
  localparam logic [2:0] GREEN   = 3'd2;
  localparam logic [2:0] CYAN    = 3'd3;
  localparam logic [2:0] RED     = 3'd4;
  localparam logic [2:0] MAGENTA = 3'd5;
  localparam logic [2:0] YELLOW  = 3'd6;
  localparam logic [2:0] WHITE   = 3'd7;

  typedef enum logic {
    MODE_LOOKUP = 1'b0,
    MODE_CYCLE  = 1'b1
  } mode_e;

  typedef enum logic {
    LOOKUP,
    CYCLE
  } state_e;

  // Default colour code of palette entry idx (entries repeat every 8)
  function automatic logic [2:0] default_code(input int unsigned idx);
    return 3'(idx % 8);
  endfunction

endpackage

// File: rtl/rgb_palette_mem.sv
// Register-array palette: reset-to-default contents, one write port and a
// registered write-first read port.
module rgb_palette_mem
  import rgb_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CH_W   = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 3 * CH_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  function automatic logic [DATA_W-1:0] default_entry(input int unsigned i);
    logic [2:0] code;
    code = default_code(i);
    return {{CH_W{code[2]}}, {CH_W{code[1]}}, {CH_W{code[0]}}};
  endfunction

  // Palette storage and read register; a same-index write bypasses to the read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= default_entry(i);
      end
      rd_data_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_addr] <= wr_data;
      end
      if (rd_en) begin
        rd_data_q <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem_q[rd_addr];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/rgb_palette.sv
// Colour palette top: lookup / auto-cycle FSM, sequencer with dwell counter,
// and the registered index/valid outputs that accompany the palette read.
module rgb_palette
  import rgb_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CH_W   = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 3 * CH_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              mode,
  input  logic [ADDR_W-1:0] colour,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [15:0]       dwell,
  output logic [DATA_W-1:0] rgb,
  output logic              rgb_valid,
  output logic [ADDR_W-1:0] cur_index
);

  state_e            state_q, state_d;
  mode_e             mode_sel;
  logic [ADDR_W-1:0] seq_q, seq_d, eff_seq;
  logic [15:0]       cnt_q, cnt_d, eff_cnt;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  assign mode_sel = mode_e'(mode);

  // Next state, sequencer/dwell update and read request selection.
  // The mode input acts in the same cycle; state_q only marks whether the
  // sequencer was already running, so entering CYCLE starts from index 0.
  always_comb begin
    state_d = (mode_sel == MODE_CYCLE) ? CYCLE : LOOKUP;
    eff_seq = (state_q == CYCLE) ? seq_q : '0;
    eff_cnt = (state_q == CYCLE) ? cnt_q : '0;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    rd_addr = colour;
    if (mode_sel == MODE_CYCLE) begin
      seq_d   = eff_seq;
      cnt_d   = eff_cnt;
      rd_addr = eff_seq;
      if (enable) begin
        if (eff_cnt == dwell) begin
          cnt_d = '0;
          seq_d = eff_seq + 1'b1;
        end else begin
          cnt_d = eff_cnt + 16'd1;
        end
      end
    end
    rd_en   = enable;
    valid_d = enable;
    idx_d   = enable ? rd_addr : idx_q;
  end

  // State, sequencer and output-qualifier registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOOKUP;
      seq_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  rgb_palette_mem #(
    .DEPTH (DEPTH),
    .CH_W  (CH_W),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rgb)
  );

  assign rgb_valid = valid_q;
  assign cur_index = idx_q;

endmodule

// File: doc/rgb_palette.md
# rgb_palette

Parametrised, runtime-writable colour palette that maps a colour index to a packed 24-bit (default) RGB code. It is the successor of the fixed 8-entry colour converter. It adds configurable depth and channel width, a write port for reprogramming entries, and an auto-cycle mode that steps through the palette with a programmable dwell time. It sits between colour-index sources (switches, counters) and display/LED drivers.

## Interface
Parameters:
- `DEPTH`, 8: number of palette entries; power of two, ≥ 2.
- `CH_W`, 8: bits per colour channel.
- `ADDR_W`, `$clog2(DEPTH)`: index width (derived, not overridden).
- `DATA_W`, `3*CH_W`: packed entry width as `{R,G,B}` (derived).

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `enable`  in  1  — qualifies reads in lookup mode; advances/freezes the sequencer in cycle mode.
- `mode`  in  1  — 0 = lookup, 1 = auto-cycle.
- `colour`  in  `ADDR_W`  — lookup index; used in lookup mode only.
- `wr_en`  in  1  — palette write strobe.
- `wr_addr`  in  `ADDR_W`  — write index.
- `wr_data`  in  `DATA_W`  — write value `{R,G,B}`.
- `dwell`  in  16  — cycle mode: an enabled index is held for `dwell+1` enabled cycles.
- `rgb`  out  `DATA_W`  — registered palette output.
- `rgb_valid`  out  1  — `rgb` updated this cycle.
- `cur_index`  out  `ADDR_W`  — index that produced the current `rgb`.

## Operation
Reset (`rst_n` low at an edge):
- Entry i is loaded with default colour `i mod 8`:
  - bit2 → R = all ones, bit1 → G = all ones, bit0 → B = all ones; other channels zero.
  - Examples: 0 = black, 4 = red, 7 = white.
- Outputs: `rgb`=0, `rgb_valid`=0, `cur_index`=0.
- State → LOOKUP; dwell counter = 0.

FSM states:
- **LOOKUP**, entered when `mode`=0.
  - `enable`=1: read `colour`.
  - `enable`=0: no read; `rgb` and `cur_index` hold; `rgb_valid`=0.
- **CYCLE**, entered when `mode`=1.
  - The sequencer index `seq` is read every enabled cycle.
  - The dwell counter increments per enabled cycle. When it equals `dwell`, it clears and `seq` increments, wrapping `DEPTH-1` → 0.
  - `enable`=0 freezes `seq` and the counter; `rgb_valid`=0.

Transitions:
- LOOKUP→CYCLE on `mode`=1: `seq` and the dwell counter clear to 0.
- CYCLE→LOOKUP on `mode`=0: the sequencer is abandoned; lookups resume the same cycle.

Writes:
- Accepted every cycle `wr_en`=1, in any state and independent of `enable`.
- Read/write collision to the same index in the same cycle is write-first: the output shows `wr_data`.

Arithmetic: the index wraps modulo `DEPTH`; there are no saturating paths.

## Timing
- Read latency is 1 cycle. A request in cycle N (index sampled at edge N) yields `rgb`, `cur_index` and `rgb_valid`=1 after that edge. These are visible during cycle N+1.
- A write at edge N is visible to any read sampled at edge N (forwarded) or later.
- Cycle mode with `dwell`=D: each index is shown for D+1 consecutive enabled cycles. `dwell` is sampled at each comparison; a change takes effect on the current hold.
- First valid output after reset: cycle 1 following the first enabled request.
- Reset mid-operation restores the defaults at that edge. Prior writes are lost.

## Structure
- Package `rgb_pkg`: default 3-bit colour encodings (`BLACK`…`WHITE`), the `mode_e` enum, and the `state_e` {LOOKUP, CYCLE}.
- Sub-module `rgb_palette_mem`: register-array palette with reset-to-default, write port, registered write-first read.
- Top `rgb_palette` holds the FSM, sequencer, dwell counter and output valid.

## Test plan
- **Reset defaults:** reset, then in lookup mode read indices 0–7 back-to-back with `enable`=1.
  - Each read gives `rgb` one cycle later: 0x000000, 0x0000FF, 0x00FF00, 0x00FFFF, 0xFF0000, 0xFF00FF, 0xFFFF00, 0xFFFFFF.
  - `rgb_valid` stays high throughout.
- **Write then read:** write 0x123456 to entry 5, then read 5.
  - `rgb`=0x123456, `cur_index`=5.
  - A write to entry 5 with `enable`=0 produces no output change.
- **Collision:** same cycle, `wr_en`=1 with addr 3 / data 0xABCDEF and a read of `colour`=3.
  - Next cycle `rgb`=0xABCDEF.
- **Cycle mode:** `mode`=1, `dwell`=2, `enable`=1.
  - `cur_index` sequence is 0,0,0,1,1,1,…,7,7,7,0.
  - Dropping `enable` for 4 cycles mid-hold freezes the index and clears `rgb_valid`; the hold resumes where it stopped.
- **Reset mid-operation:** write entry 1 = 0x111111, run cycle mode, then pulse `rst_n` low for 1 cycle.
  - Outputs are 0 and the state is LOOKUP.
  - Reading 1 returns 0x0000FF.
- **Parameter sweep:** `DEPTH`=16, `CH_W`=4.
  - Entry 12 reads 0xF00.
  - Cycle mode with `dwell`=0 wraps 15→0.
